// File: rtl/dac_pkg.sv
// Shared types and helpers for the DAC7512 serial write path.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package dac_pkg;

  // Bits per DAC7512 frame: two don't-care bits, two power-down bits, twelve data bits.
  localparam int FRAME_BITS = 16;

  // Half-period ticks spent in SHIFT: one per SCLK edge after the setup fall,
  // plus a closing high half-period before sync is released.
  localparam int SHIFT_TICKS = 2 * FRAME_BITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  // Frame word as the DAC expects it on the wire, MSB first.
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [1:0]  pd,
                                                       input logic [11:0] data);
    return {2'b00, pd, data};
  endfunction

endpackage

// File: rtl/dac_half_tick.sv
// Half-period timer: pulses tick once every DIV_HALF clk cycles.
// Latency: first tick DIV_HALF cycles after a restart (restart seen at edge e -> tick acts at e+DIV_HALF).
// Backpressure: none; free-running between restarts.
module dac_half_tick #(
  parameter int DIV_HALF = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(DIV_HALF + 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV_HALF - 1));

  // Count up to DIV_HALF-1 and fold back; a restart realigns the phase to the new state.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dac7512_wr.sv
// Serial writer for a DAC7512: 16-bit frames on SCLK/SYNC_N/DIN with a one-deep pending word.
// Latency: sync_n falls one edge after wr_req; sync_n is low for 33*DIV_HALF cycles per frame.
// Backpressure: none upstream; a second request while a word is pending overwrites it and pulses ovf.
module dac7512_wr #(
  parameter int DIV_HALF = 20,
  parameter int GAP_CYC  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [11:0] dac_data,
  input  logic [1:0]  dac_pd,
  output logic        dac_sclk,
  output logic        dac_sync_n,
  output logic        dac_din,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  import dac_pkg::*;

  localparam int HW = $clog2(SHIFT_TICKS);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_t                state;
  state_t                next_state;
  logic                  tick;
  logic                  restart;
  logic [HW-1:0]         hcnt;
  logic [GW-1:0]         gap_cnt;
  logic                  gap_end;
  logic                  last_tick;
  logic                  trail_tick;
  logic                  consume;
  logic                  store;
  logic                  enter_setup;
  logic                  pend_vld;
  logic [FRAME_BITS-1:0] pend_word;
  logic [FRAME_BITS-1:0] in_word;
  logic [FRAME_BITS-1:0] start_word;
  logic [FRAME_BITS-2:0] sh;

  assign in_word     = frame_word(dac_pd, dac_data);
  assign start_word  = consume ? pend_word : in_word;
  assign restart     = (next_state != state);
  assign enter_setup = (next_state == S_SETUP) && (state != S_SETUP);
  assign last_tick   = (hcnt == HW'(SHIFT_TICKS - 1));
  assign trail_tick  = (hcnt == HW'(SHIFT_TICKS - 2));
  assign gap_end     = (gap_cnt == GW'(GAP_CYC - 1));
  // Any request that does not start a frame straight from an empty IDLE goes to the pending slot.
  assign store       = wr_req && !((state == S_IDLE) && !pend_vld);

  dac_half_tick #(
    .DIV_HALF (DIV_HALF)
  ) u_half_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; consume marks the cycle the pending word is handed to a new frame.
  always_comb begin
    next_state = state;
    consume    = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_vld) begin
          next_state = S_SETUP;
          consume    = 1'b1;
        end else if (wr_req) begin
          next_state = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tick) begin
          next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (tick && last_tick) begin
          next_state = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_end) begin
          if (pend_vld) begin
            next_state = S_SETUP;
            consume    = 1'b1;
          end else begin
            next_state = S_IDLE;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Half-period and gap counters, cleared on every state entry and never wrapping.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      hcnt    <= '0;
      gap_cnt <= '0;
    end else begin
      if ((state == S_SHIFT) && tick && !last_tick) begin
        hcnt <= hcnt + HW'(1);
      end
      if ((state == S_GAP) && !gap_end) begin
        gap_cnt <= gap_cnt + GW'(1);
      end
    end
  end

  // Single-entry pending slot: latest word wins, overwriting a still-valid word flags ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld  <= 1'b0;
      pend_word <= '0;
      ovf       <= 1'b0;
    end else begin
      ovf <= store && pend_vld && !consume;
      if (store) begin
        pend_vld  <= 1'b1;
        pend_word <= in_word;
      end else if (consume) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // Serial pins: din only moves together with a rising sclk so it is stable while sclk is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      dac_sclk   <= 1'b1;
      dac_sync_n <= 1'b1;
      dac_din    <= 1'b0;
      done       <= 1'b0;
      sh         <= '0;
    end else begin
      done <= 1'b0;
      if (enter_setup) begin
        dac_sync_n <= 1'b0;
        dac_sclk   <= 1'b1;
        dac_din    <= start_word[FRAME_BITS-1];
        sh         <= start_word[FRAME_BITS-2:0];
      end else if ((state == S_SETUP) && tick) begin
        dac_sclk <= 1'b0;
      end else if ((state == S_SHIFT) && tick) begin
        if (last_tick) begin
          // Closing high half-period is over: release the frame.
          dac_sync_n <= 1'b1;
          dac_din    <= 1'b0;
          done       <= 1'b1;
        end else begin
          // Even hcnt is a rising edge, odd hcnt a falling edge.
          dac_sclk <= ~hcnt[0];
          if (!hcnt[0] && !trail_tick) begin
            dac_din <= sh[FRAME_BITS-2];
            sh      <= {sh[FRAME_BITS-3:0], 1'b0};
          end
        end
      end
    end
  end

  // busy stays up for one cycle after returning to IDLE so it spans the whole gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
    end else begin
      busy <= (state != S_IDLE) || (next_state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_dac7512_wr.sv
// Directed bench for dac7512_wr: single write, back-to-back, overwrite, coincident request, reset abort.
// Latency: checks sync_n low window of 33*D and a gap of G cycles between frames.
// Backpressure: a wire-level monitor decodes every frame and checks din stability and edge count.
module tb_dac7512_wr;

  localparam int D   = 20;
  localparam int G   = 4;
  localparam int LIM = 5000;

  logic        clk;
  logic        rst;
  logic        wr_req;
  logic [11:0] dac_data;
  logic [1:0]  dac_pd;
  logic        dac_sclk;
  logic        dac_sync_n;
  logic        dac_din;
  logic        busy;
  logic        done;
  logic        ovf;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int ovf_cnt  = 0;
  int n;
  int f;
  int ovf0;
  int d0;
  logic ps;
  bit   abort = 1'b0;

  logic [15:0] words[$];

  // Monitor state
  int          falls = 0;
  int          viol  = 0;
  logic [15:0] cap   = '0;
  logic        p_sclk = 1'b1;
  logic        p_din  = 1'b0;
  logic        p_sync = 1'b1;

  dac7512_wr #(
    .DIV_HALF (D),
    .GAP_CYC  (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .dac_data   (dac_data),
    .dac_pd     (dac_pd),
    .dac_sclk   (dac_sclk),
    .dac_sync_n (dac_sync_n),
    .dac_din    (dac_din),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [11:0] d, input logic [1:0] p);
    wr_req   = 1'b1;
    dac_data = d;
    dac_pd   = p;
    @(negedge clk);
    wr_req   = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] exp);
    logic [15:0] w;
    w = 16'hxxxx;
    if (words.size() > 0) w = words.pop_front();
    chk(tag, {16'h0, w}, {16'h0, exp});
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < LIM) begin
      k++;
      @(negedge clk);
    end
    chk(tag, {31'h0, busy}, 32'h0);
  endtask

  task automatic wait_rise(input string tag);
    int k;
    k = 0;
    while (dac_sync_n !== 1'b1 && k < LIM) begin
      k++;
      @(negedge clk);
    end
    chk(tag, {31'h0, dac_sync_n}, 32'h1);
  endtask

  // Wire-level frame decoder: samples bits on falling sclk inside each sync_n low window.
  always @(negedge clk) begin
    if (dac_sync_n === 1'b0) begin
      if (p_sync === 1'b1) begin
        falls = 0;
        viol  = 0;
        cap   = '0;
      end
      if (p_sclk === 1'b1 && dac_sclk === 1'b0) begin
        falls++;
        cap = {cap[14:0], dac_din};
      end
      if (p_sclk === 1'b0 && dac_sclk === 1'b0 && dac_din !== p_din) viol++;
    end else if (p_sync === 1'b0) begin
      if (abort) begin
        abort = 1'b0;
      end else begin
        chk("mon_falls", falls, 16);
        chk("mon_din_stable", viol, 0);
        words.push_back(cap);
      end
    end
    if (done === 1'b1) done_cnt++;
    if (ovf === 1'b1) ovf_cnt++;
    p_sclk = dac_sclk;
    p_din  = dac_din;
    p_sync = dac_sync_n;
  end

  initial begin
    rst      = 1'b1;
    wr_req   = 1'b0;
    dac_data = '0;
    dac_pd   = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_sclk",   {31'h0, dac_sclk},   32'h1);
    chk("rst_sync_n", {31'h0, dac_sync_n}, 32'h1);
    chk("rst_din",    {31'h0, dac_din},    32'h0);
    chk("rst_busy",   {31'h0, busy},       32'h0);
    chk("rst_done",   {31'h0, done},       32'h0);
    chk("rst_ovf",    {31'h0, ovf},        32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single write of 0xA5C
    send(12'hA5C, 2'b00);
    chk("t2_start_sync", {31'h0, dac_sync_n}, 32'h0);
    chk("t2_start_din",  {31'h0, dac_din},    32'h0);
    chk("t2_start_sclk", {31'h0, dac_sclk},   32'h1);
    chk("t2_start_busy", {31'h0, busy},       32'h1);
    n = 0;
    while (dac_sync_n === 1'b0 && n < LIM) begin
      n++;
      @(negedge clk);
    end
    chk("t2_low_cycles", n, 33 * D);
    chk("t2_done",     {31'h0, done},     32'h1);
    chk("t2_gap_sclk", {31'h0, dac_sclk}, 32'h1);
    chk("t2_gap_din",  {31'h0, dac_din},  32'h0);
    repeat (G) @(negedge clk);
    chk("t2_busy_hold", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("t2_busy_drop", {31'h0, busy}, 32'h0);
    chk("t2_done_cnt", done_cnt, 1);
    pop_chk("t2_word", 16'h0A5C);

    // Back-to-back: second request mid-frame
    repeat (3) @(negedge clk);
    send(12'h456, 2'b01);
    repeat (100) @(negedge clk);
    send(12'h123, 2'b00);
    wait_rise("t3_rise");
    n = 0;
    while (dac_sync_n === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("t3_gap_len", n, G);
    wait_idle("t3_idle");
    chk("t3_ovf_cnt", ovf_cnt, 0);
    pop_chk("t3_word0", 16'h1456);
    pop_chk("t3_word1", 16'h0123);

    // Overwrite of the pending word
    ovf0 = ovf_cnt;
    send(12'h001, 2'b00);
    repeat (50) @(negedge clk);
    send(12'h002, 2'b00);
    chk("t4_no_ovf_first", {31'h0, ovf}, 32'h0);
    repeat (50) @(negedge clk);
    send(12'h003, 2'b00);
    chk("t4_ovf_pulse", {31'h0, ovf}, 32'h1);
    @(negedge clk);
    chk("t4_ovf_single", {31'h0, ovf}, 32'h0);
    wait_idle("t4_idle");
    chk("t4_ovf_cnt", ovf_cnt - ovf0, 1);
    pop_chk("t4_word0", 16'h0001);
    pop_chk("t4_word1", 16'h0003);

    // Request coinciding with pending consumption
    ovf0 = ovf_cnt;
    send(12'hAAA, 2'b00);
    repeat (50) @(negedge clk);
    send(12'h555, 2'b00);
    wait_rise("t5_rise");
    repeat (G - 1) @(negedge clk);
    wr_req   = 1'b1;
    dac_data = 12'h7FF;
    dac_pd   = 2'b00;
    @(negedge clk);
    wr_req = 1'b0;
    chk("t5_no_ovf",     {31'h0, ovf},        32'h0);
    chk("t5_next_frame", {31'h0, dac_sync_n}, 32'h0);
    wait_idle("t5_idle");
    chk("t5_ovf_cnt", ovf_cnt - ovf0, 0);
    pop_chk("t5_word0", 16'h0AAA);
    pop_chk("t5_word1", 16'h0555);
    pop_chk("t5_word2", 16'h07FF);

    // Reset after the 7th falling sclk edge
    d0 = done_cnt;
    send(12'hABC, 2'b00);
    f  = 0;
    n  = 0;
    ps = dac_sclk;
    while (f < 7 && n < LIM) begin
      @(negedge clk);
      if (ps === 1'b1 && dac_sclk === 1'b0) f++;
      ps = dac_sclk;
      n++;
    end
    chk("t6_fall7", f, 7);
    rst      = 1'b1;
    abort    = 1'b1;
    wr_req   = 1'b1;
    dac_data = 12'h111;
    @(negedge clk);
    chk("t6_sync_n", {31'h0, dac_sync_n}, 32'h1);
    chk("t6_sclk",   {31'h0, dac_sclk},   32'h1);
    chk("t6_din",    {31'h0, dac_din},    32'h0);
    chk("t6_busy",   {31'h0, busy},       32'h0);
    chk("t6_done",   {31'h0, done},       32'h0);
    rst    = 1'b0;
    wr_req = 1'b0;
    @(negedge clk);
    chk("t6_req_ignored", {31'h0, busy}, 32'h0);
    repeat (5) @(negedge clk);
    chk("t6_no_done", done_cnt, d0);
    send(12'hFFF, 2'b00);
    wait_idle("t6_idle");
    pop_chk("t6_word", 16'h0FFF);

    // Totals over all scenarios
    repeat (5) @(negedge clk);
    chk("end_done_cnt", done_cnt, 9);
    chk("end_ovf_cnt",  ovf_cnt, 1);
    chk("end_words_left", words.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac7512_wr.md
DAC7512_WR -- requirements
Module: dac7512_wr

Interface
REQ-001 Parameter DIV_HALF, default 20, SHALL set the number of clk cycles per SCLK half-period (20 gives 1 MHz SCLK at 40 MHz clk); legal range 2..63.
REQ-002 Parameter GAP_CYC, default 4, SHALL set the minimum number of clk cycles dac_sync_n stays high between frames; legal range 1..63.
REQ-003 clk  input  1  system clock, 40 MHz.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 wr_req  input  1  one-cycle write request, already synchronous to clk.
REQ-006 dac_data  input  12  DAC code, sampled in the cycle wr_req is high.
REQ-007 dac_pd  input  2  power-down bits, sampled with dac_data.
REQ-008 dac_sclk  output  1  serial clock to the DAC, idles high.
REQ-009 dac_sync_n  output  1  active-low frame sync to the DAC.
REQ-010 dac_din  output  1  serial data to the DAC, MSB first.
REQ-011 busy  output  1  high while a frame or inter-frame gap is in progress.
REQ-012 done  output  1  one-cycle pulse marking the end of a frame.
REQ-013 ovf  output  1  one-cycle pulse when a pending word is overwritten.

Function
REQ-014 The frame word SHALL be {2'b00, dac_pd, dac_data}, 16 bits, shifted MSB first.
REQ-015 The FSM SHALL have exactly four states: IDLE, SETUP, SHIFT and GAP.
REQ-016 IDLE: when wr_req=1 at edge t, the word SHALL be latched, the FSM SHALL enter SETUP, and at t+1 dac_sync_n=0, dac_din=bit15, dac_sclk=1 and busy=1.
REQ-017 SETUP SHALL last DIV_HALF cycles, after which dac_sclk SHALL fall and the FSM SHALL enter SHIFT.
REQ-018 SHIFT: dac_sclk SHALL toggle every DIV_HALF cycles.
REQ-019 On each SHIFT rising edge of dac_sclk, dac_din SHALL advance to the next bit; dac_din SHALL never change while dac_sclk is low.
REQ-020 After the 16th falling edge, dac_sclk SHALL rise after DIV_HALF cycles; in that same cycle dac_sync_n=1, done=1 for one cycle, and the FSM SHALL enter GAP.
REQ-021 From dac_sync_n falling to dac_sync_n rising SHALL be exactly 33*DIV_HALF clk cycles.
REQ-022 GAP SHALL hold dac_sync_n=1, dac_sclk=1 and dac_din=0 for GAP_CYC cycles.
REQ-023 At the end of GAP: if a word is pending, the FSM SHALL enter SETUP with it; otherwise it SHALL enter IDLE with busy=0 in the next cycle.
REQ-024 wr_req while busy=1 SHALL store the word in a single-entry pending register, latest value winning.
REQ-025 If the pending register is already full when wr_req arrives, ovf SHALL pulse for one cycle.
REQ-026 wr_req in the same cycle the pending word is consumed (GAP to SETUP) SHALL refill pending with the new word and SHALL NOT raise ovf.
REQ-027 Input words SHALL never be dropped silently; the only loss is the overwrite flagged by ovf.
REQ-028 Bit and half-period counters SHALL be sized for their maximum value and SHALL reset to 0 on each state entry, with no wrap-around.

Reset
REQ-029 rst=1 SHALL, at the next edge, force the FSM to IDLE and clear the pending register.
REQ-030 Reset values SHALL be: dac_sclk=1, dac_sync_n=1, dac_din=0, busy=0, done=0, ovf=0.
REQ-031 rst asserted mid-frame SHALL abort the frame immediately with no done pulse; wr_req is ignored while rst=1.

Structure
REQ-032 Package dac_pkg SHALL hold the state enum, FRAME_BITS=16, and the frame-word composition function.
REQ-033 One sub-module, dac_half_tick, SHALL generate a one-cycle tick every DIV_HALF cycles, with a synchronous restart input driven on each state entry; all other logic stays in dac7512_wr.

Verification
REQ-034 Single write: dac_data=12'hA5C, dac_pd=0, DIV_HALF=20 -> shifted bits 0x0A5C; sync_n low for 660 cycles; done pulses once; busy drops GAP_CYC+1 cycles after done.
REQ-035 Back-to-back: second wr_req (12'h123) mid-frame -> second frame starts exactly GAP_CYC cycles after the first sync_n rise; ovf=0.
REQ-036 Overwrite: three wr_req (0x001, 0x002, 0x003) during one frame -> ovf pulses once; next frame carries 0x003.
REQ-037 Coincident request: wr_req=0x7FF in the cycle pending is consumed -> both words transmitted in order; ovf=0.
REQ-038 Reset mid-frame: rst after the 7th falling SCLK edge -> next cycle sync_n=1, sclk=1, din=0, busy=0; no done; a following write of 0xFFF transmits correctly.
REQ-039 Protocol checker: over all scenarios, din is stable while sclk is low and exactly 16 falling edges occur per sync_n low window.
